multicycle_ctrl: RTL

Multi-cycle control unit for the RV32I core: fetches an instruction over the memory handshake, holds it in an internal instruction register, decodes it and sequences the datapath through execute, memory and write-back. It is the producer side of the ALU control interface. It drives the 5-bit `Upr_ALU` operation code and consumes the ALU branch flag `C`. It also generates the immediate and all register-file, PC and memory strobes.

---
 rtl/rv_ctrl_pkg.sv | 75 +++++++
 rtl/multicycle_ctrl_if.sv | 22 ++
 rtl/multicycle_ctrl_imm_gen.sv | 21 ++
 rtl/multicycle_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the RV32I multi-cycle control unit: ALU codes,
// opcodes, FSM state encoding, mux select encodings and the ALU op decode.
package rv_ctrl_pkg;

  // ALU operation codes driven on Upr_ALU
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_SLL  = 5'b00001;
  localparam logic [4:0] ALU_SLTS = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_EQ   = 5'b11000;
  localparam logic [4:0] ALU_NE   = 5'b11001;
  localparam logic [4:0] ALU_LTS  = 5'b11100;
  localparam logic [4:0] ALU_GES  = 5'b11101;
  localparam logic [4:0] ALU_LTU  = 5'b11110;
  localparam logic [4:0] ALU_GEU  = 5'b11111;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Control FSM states
  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  // Mux select encodings
  localparam logic       ADDR_PC   = 1'b0;
  localparam logic       ADDR_ALU  = 1'b1;
  localparam logic [1:0] A_RS1     = 2'd0;
  localparam logic [1:0] A_PC      = 2'd1;
  localparam logic [1:0] A_ZERO    = 2'd2;
  localparam logic [1:0] B_RS2     = 2'd0;
  localparam logic [1:0] B_IMM     = 2'd1;
  localparam logic [1:0] B_FOUR    = 2'd2;
  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_IMM    = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  // ALU operation for an instruction word; non-ALU classes compute an address/sum
  function automatic logic [4:0] alu_op(input logic [31:0] ir);
    logic [4:0] op;
    op = ALU_ADD;
    case (ir[6:0])
      OPC_OP:     op = {1'b0, ir[30], ir[14:12]};
      OPC_OP_IMM: op = {1'b0, (ir[14:12] == 3'b101) ? ir[30] : 1'b0, ir[14:12]};
      OPC_BRANCH: op = {2'b11, ir[14:12]};
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request bus between the control unit (master) and memory (slave).
// Handshake: the master raises mem_req with mem_we/mem_size/addr_sel stable and
// holds all of them until it samples mem_ready=1 on a rising edge; that edge
// completes the transfer. mem_ready is meaningless while mem_req=0.
interface multicycle_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_size;
  logic        addr_sel;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_size, addr_sel,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_size, addr_sel,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl_imm_gen.sv
// Immediate generator: instruction register to sign-extended 32-bit immediate.
module imm_gen
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm
);

  // Pick the immediate format from the opcode; I-format is the fallback
  always_comb begin
    imm = {{20{ir[31]}}, ir[31:20]};
    case (ir[6:0])
      OPC_STORE:            imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH:           imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:   imm = {ir[31:12], 12'b0};
      OPC_JAL:              imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:              imm = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control unit: fetch into IR, decode, then sequence the
// datapath through EXEC/MEM/WB. Only state, IR and the illegal flag are
// registered; every strobe is combinational from state plus IR, so an
// asynchronous reset drops them immediately.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   mem,
  input  logic                C,
  output logic [4:0]          Upr_ALU,
  output logic [1:0]          a_sel,
  output logic [1:0]          b_sel,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd,
  output logic [31:0]         imm,
  output logic                rf_we,
  output logic [1:0]          wb_sel,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic                illegal,
  output state_t              dbg_state
);

  state_t      state, next_state;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, is_branch, is_jump, legal;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign rs1       = ir[19:15];
  assign rs2       = ir[24:20];
  assign rd        = ir[11:7];
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);
  assign Upr_ALU   = alu_op(ir);
  assign dbg_state = state;

  imm_gen u_imm_gen (
    .ir  (ir),
    .imm (imm)
  );

  // Legality: known opcode, R-type funct7 of 0/0x20, no branch funct3 010/011
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_OP:     legal = (ir[31:25] == 7'b0000000) || (ir[31:25] == 7'b0100000);
      OPC_BRANCH: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: legal = 1'b1;
      default:    legal = 1'b0;
    endcase
  end

  // ALU operand selection from the instruction class
  always_comb begin
    a_sel = A_RS1;
    b_sel = B_RS2;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR: b_sel = B_IMM;
      OPC_LUI:   begin a_sel = A_ZERO; b_sel = B_IMM; end
      OPC_AUIPC,
      OPC_JAL:   begin a_sel = A_PC;   b_sel = B_IMM; end
      default:   ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_START;
    else        state <= next_state;
  end

  // Instruction register loads only when a fetch completes; illegal is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      if (state == ST_FETCH && mem.mem_ready) ir <= mem.mem_rdata;
      if (state == ST_DECODE && !legal)       illegal <= 1'b1;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    next_state   = state;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.mem_size = SIZE_WORD;
    mem.addr_sel = ADDR_PC;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;
    unique case (state)
      ST_START:  next_state = ST_FETCH;
      ST_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) next_state = ST_DECODE;
      end
      ST_DECODE: next_state = legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        if (is_branch) begin
          pc_we      = 1'b1;
          pc_src     = C ? PC_IMM : PC_PLUS4;
          next_state = ST_FETCH;
        end else if (is_load || is_store) begin
          next_state = ST_MEM;
        end else begin
          next_state = ST_WB;
        end
      end
      ST_MEM: begin
        mem.mem_req  = 1'b1;
        mem.addr_sel = ADDR_ALU;
        mem.mem_we   = is_store;
        mem.mem_size = funct3;
        if (mem.mem_ready) begin
          if (is_store) begin
            pc_we      = 1'b1;
            next_state = ST_FETCH;
          end else begin
            next_state = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        next_state = ST_FETCH;
        if (is_load) begin
          wb_sel = WB_MEM;
        end else if (is_jump) begin
          wb_sel = WB_PC4;
          pc_src = PC_ALU;
        end
      end
      ST_TRAP:   next_state = ST_TRAP;
      default:   next_state = ST_START;
    endcase
  end

endmodule
